seq_fsm: RTL and testbench

Parametrised note-sequencer control FSM for the lab synthesizer datapath. Holds a writable table of NUM_NOTES frequency-control words, steps through it forward or backward at a fixed note rate, and supports pause, edit-in-place and one-shot or looping playback. Drives the NCO `fcw` input and the user status LEDs, and takes single-cycle button pulses from the upstream debouncer/edge detector.

---
 rtl/seq_fsm.sv | 150 +++++++++++++++
 tb/tb_seq_fsm.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/seq_fsm.sv
`default_nettype none
// ============================================================================
// Module   : seq_fsm
// Brief    : Note-sequencer control FSM. Plays a writable table of frequency
//            control words forward/backward with pause and in-place editing.
// Revision : 1.0 - initial release
// ============================================================================
module seq_fsm #(
    parameter int CYCLES_PER_NOTE = 125_000_000,
    parameter int NUM_NOTES       = 8,
    parameter int FCW_WIDTH       = 24,
    parameter int BASE_FCW        = 67934,
    parameter int NOTE_STEP       = 1000,
    parameter int EDIT_STEP       = 1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           buttons,
    input  logic                 loop_en,
    output logic [FCW_WIDTH-1:0] fcw,
    output logic [NUM_NOTES-1:0] leds,
    output logic [1:0]           leds_state
);

    localparam int IW = $clog2(NUM_NOTES);
    localparam int TW = $clog2(CYCLES_PER_NOTE);
    localparam int SW = FCW_WIDTH + 32;

    localparam logic [IW-1:0] c_last_idx  = IW'(NUM_NOTES - 1);
    localparam logic [TW-1:0] c_last_tick = TW'(CYCLES_PER_NOTE - 1);
    localparam logic [SW-1:0] c_edit_step = SW'(EDIT_STEP);
    localparam logic [SW-1:0] c_fcw_max   = {{32{1'b0}}, {FCW_WIDTH{1'b1}}};

    typedef enum logic [1:0] {
        ST_PLAY    = 2'b00,
        ST_REVERSE = 2'b01,
        ST_PAUSE   = 2'b10,
        ST_EDIT    = 2'b11
    } state_t;

    state_t               state_q, state_d;
    logic                 dir_rev_q, dir_rev_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [FCW_WIDTH-1:0] note_q [NUM_NOTES];
    logic [FCW_WIDTH-1:0] note_d [NUM_NOTES];
    logic [FCW_WIDTH-1:0] fcw_q, fcw_d;
    logic [NUM_NOTES-1:0] leds_q, leds_d;

    logic                 w_b_edit, w_b_up, w_b_down, w_b_next;
    logic [SW-1:0]        w_cur, w_sum, w_diff;

    // Only the highest-priority pressed button survives decoding.
    always_comb begin
        w_b_edit = buttons[2];
        w_b_up   = buttons[0] & ~buttons[2];
        w_b_down = buttons[1] & ~buttons[0] & ~buttons[2];
        w_b_next = buttons[3] & ~(|buttons[2:0]);
        w_cur    = SW'(note_q[idx_q]);
        w_sum    = w_cur + c_edit_step;
        w_diff   = w_cur - c_edit_step;
    end

    always_comb begin
        state_d   = state_q;
        dir_rev_d = dir_rev_q;
        idx_d     = idx_q;
        timer_d   = timer_q;
        note_d    = note_q;

        case (state_q)
            ST_PLAY, ST_REVERSE: begin
                if (w_b_edit) begin
                    state_d = ST_EDIT;
                end else if (w_b_up) begin
                    state_d = ST_PAUSE;
                end else if (w_b_down) begin
                    state_d = (state_q == ST_PLAY) ? ST_REVERSE : ST_PLAY;
                end else if (timer_q == c_last_tick) begin
                    timer_d = '0;
                    if (state_q == ST_PLAY) begin
                        if (idx_q != c_last_idx) idx_d = idx_q + IW'(1);
                        else if (loop_en)        idx_d = '0;
                        else                     state_d = ST_PAUSE;
                    end else begin
                        if (idx_q != '0)         idx_d = idx_q - IW'(1);
                        else if (loop_en)        idx_d = c_last_idx;
                        else                     state_d = ST_PAUSE;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_PAUSE: begin
                if (w_b_edit)    state_d = ST_EDIT;
                else if (w_b_up) state_d = dir_rev_q ? ST_REVERSE : ST_PLAY;
            end
            default: begin
                if (w_b_edit) begin
                    state_d = ST_PLAY;
                end else if (w_b_up) begin
                    note_d[idx_q] = (w_sum > c_fcw_max) ? c_fcw_max[FCW_WIDTH-1:0]
                                                        : w_sum[FCW_WIDTH-1:0];
                end else if (w_b_down) begin
                    note_d[idx_q] = (w_cur < c_edit_step) ? '0 : w_diff[FCW_WIDTH-1:0];
                end else if (w_b_next) begin
                    idx_d = (idx_q == c_last_idx) ? '0 : idx_q + IW'(1);
                end
            end
        endcase

        // Any state change restarts the note period and latches playback direction.
        if (state_d != state_q) begin
            timer_d = '0;
            if (state_d == ST_PLAY)    dir_rev_d = 1'b0;
            if (state_d == ST_REVERSE) dir_rev_d = 1'b1;
        end

        fcw_d  = (state_q == ST_PAUSE) ? '0 : note_q[idx_q];
        leds_d = NUM_NOTES'(1) << idx_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_PLAY;
            dir_rev_q <= 1'b0;
            idx_q     <= '0;
            timer_q   <= '0;
            fcw_q     <= '0;
            leds_q    <= NUM_NOTES'(1);
            for (int i = 0; i < NUM_NOTES; i++) begin
                note_q[i] <= FCW_WIDTH'(BASE_FCW + i * NOTE_STEP);
            end
        end else begin
            state_q   <= state_d;
            dir_rev_q <= dir_rev_d;
            idx_q     <= idx_d;
            timer_q   <= timer_d;
            fcw_q     <= fcw_d;
            leds_q    <= leds_d;
            note_q    <= note_d;
        end
    end

    assign fcw        = fcw_q;
    assign leds       = leds_q;
    assign leds_state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_fsm
// Brief    : Directed self-checking bench for seq_fsm (24-bit and 12-bit FCW).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_fsm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rst2_n = 1'b0;
    logic [3:0]  buttons = 4'b0000;
    logic        loop_en = 1'b1;
    logic [23:0] fcw;
    logic [3:0]  leds;
    logic [1:0]  leds_state;
    logic [11:0] fcw2;
    logic [3:0]  leds2;
    logic [1:0]  leds_state2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_fsm #(
        .CYCLES_PER_NOTE(4), .NUM_NOTES(4), .FCW_WIDTH(24),
        .BASE_FCW(67934), .NOTE_STEP(1000), .EDIT_STEP(1000)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .buttons(buttons), .loop_en(loop_en),
        .fcw(fcw), .leds(leds), .leds_state(leds_state)
    );

    seq_fsm #(
        .CYCLES_PER_NOTE(4), .NUM_NOTES(4), .FCW_WIDTH(12),
        .BASE_FCW(500), .NOTE_STEP(1000), .EDIT_STEP(1000)
    ) u_dut12 (
        .clk(clk), .rst_n(rst2_n), .buttons(buttons), .loop_en(loop_en),
        .fcw(fcw2), .leds(leds2), .leds_state(leds_state2)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [3:0] b);
        buttons = b;
        step(1);
        buttons = 4'b0000;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Leaves rst_n released just after a reset edge: the next edge is the first active one.
    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    initial begin
        step(3);
        chk("rst_state", leds_state, 2'b00);
        chk("rst_leds", leds, 4'b0001);
        chk("rst_fcw", fcw, 0);
        rst_n = 1'b1;

        // Forward looping playback
        step(1);  chk("play_fcw0", fcw, 67934); chk("play_leds0", leds, 4'b0001);
        step(3);  chk("play_leds1", leds, 4'b0010);
        step(1);  chk("play_fcw1", fcw, 68934);
        step(3);  chk("play_leds2", leds, 4'b0100);
        step(1);  chk("play_fcw2", fcw, 69934);
        step(3);  chk("play_leds3", leds, 4'b1000);
        step(1);  chk("play_fcw3", fcw, 70934);
        step(3);  chk("play_wrap_leds", leds, 4'b0001);
        step(1);  chk("play_wrap_fcw", fcw, 67934); chk("play_state", leds_state, 2'b00);

        // Reverse, wrap 0 -> 3, pause and resume in reverse
        press(4'b0010); chk("rev_state", leds_state, 2'b01);
        step(4);  chk("rev_wrap_leds", leds, 4'b1000);
        step(1);  chk("rev_fcw", fcw, 70934);
        press(4'b0001); chk("pause_state", leds_state, 2'b10);
        step(1);  chk("pause_fcw", fcw, 0);
        press(4'b0010); chk("pause_ignore_b1", leds_state, 2'b10);
        press(4'b0001); chk("resume_rev", leds_state, 2'b01); chk("resume_leds", leds, 4'b1000);
        step(1);  chk("resume_fcw", fcw, 70934);

        // Button at terminal count wins over the note advance
        do_reset();
        step(3);
        press(4'b0001); chk("tc_btn_state", leds_state, 2'b10); chk("tc_btn_leds", leds, 4'b0001);

        // Edit note 0 up twice, next note, note 1 down, exit and replay
        do_reset();
        press(4'b0100); chk("edit_state", leds_state, 2'b11);
        press(4'b0001);
        press(4'b0001); chk("edit_fcw_up1", fcw, 68934);
        press(4'b1000); chk("edit_next_leds", leds, 4'b0010); chk("edit_fcw_up2", fcw, 69934);
        press(4'b0010);
        press(4'b0100); chk("edit_exit_state", leds_state, 2'b00);
        step(1);  chk("edit_exit_fcw", fcw, 67934);
        step(11); chk("replay_leds", leds, 4'b0001);
        step(1);  chk("replay_fcw", fcw, 69934);

        // One-shot playback stops at the end and re-pauses after resuming
        loop_en = 1'b0;
        do_reset();
        step(15); chk("oneshot_pre", leds_state, 2'b00);
        step(1);  chk("oneshot_state", leds_state, 2'b10); chk("oneshot_leds", leds, 4'b1000);
        step(1);  chk("oneshot_fcw", fcw, 0);
        step(1);
        press(4'b0001); chk("oneshot_resume", leds_state, 2'b00);
        step(1);  chk("oneshot_res_fcw", fcw, 70934);
        step(2);  chk("oneshot_hold", leds_state, 2'b00);
        step(1);  chk("oneshot_repause", leds_state, 2'b10); chk("oneshot_reidx", leds, 4'b1000);
        loop_en = 1'b1;

        // Simultaneous buttons, then reset mid-edit discards edits
        do_reset();
        press(4'b0111); chk("prio_state", leds_state, 2'b11); chk("prio_leds", leds, 4'b0001);
        press(4'b0001);
        press(4'b1000);
        press(4'b0001);
        press(4'b1010); chk("prio_b1_over_b3", leds, 4'b0010);
        rst_n = 1'b0;
        step(1);  chk("midrst_state", leds_state, 2'b00); chk("midrst_fcw", fcw, 0);
        chk("midrst_leds", leds, 4'b0001);
        rst_n = 1'b1;
        step(1);  chk("midrst_fcw0", fcw, 67934);
        step(4);  chk("midrst_fcw1", fcw, 68934);

        // 12-bit variant: saturation at both ends
        rst_n = 1'b0;
        rst2_n = 1'b1;
        press(4'b0100); chk("sat_state", leds_state2, 2'b11);
        press(4'b0010);
        step(1);  chk("sat_floor", fcw2, 0);
        press(4'b0001);
        press(4'b0001);
        press(4'b0001);
        press(4'b0001);
        press(4'b0001); chk("sat_4000", fcw2, 4000);
        step(1);  chk("sat_cap", fcw2, 4095);
        press(4'b0001);
        step(1);  chk("sat_hold", fcw2, 4095);
        press(4'b0010);
        step(1);  chk("sat_down", fcw2, 3095);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
